// File: rtl/instr_encoder.sv
// Streaming LEGv8 LDUR/STUR/CBZ encoder: range-checks the immediate, packs the
// instruction word, tags it with a sequential imem address and queues it.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rt,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        rej_count,
    output logic              mem_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {RUN, STOP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       hold_instr;
    logic [ADDR_W-1:0] hold_addr;
    logic              err_q;
    logic [7:0]        rej_q;
    logic              d_ok, cb_ok, legal, accept, push, pop;
    logic [31:0]       enc;

    assign d_ok  = (in_imm[63:8]  == {56{in_imm[8]}});
    assign cb_ok = (in_imm[63:18] == {46{in_imm[18]}});

    always_comb begin
        legal = 1'b0;
        enc   = '0;
        case (in_kind)
            2'b00: begin
                legal = d_ok;
                enc   = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rt};
            end
            2'b01: begin
                legal = d_ok;
                enc   = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rt};
            end
            2'b10: begin
                legal = cb_ok;
                enc   = {8'b10110100, in_imm[18:0], in_rt};
            end
            default: ;
        endcase
    end

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == RUN) && (count < FULL_CNT);
        accept   = in_valid && in_ready;
        push     = accept && legal;
        if (push && (addr_q == '1)) begin
            state_d = STOP;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= enc;
            addr_mem[wr_ptr]  <= addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            addr_q     <= '0;
            hold_instr <= '0;
            hold_addr  <= '0;
            err_q      <= 1'b0;
            rej_q      <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                // The last address parks the counter; STOP blocks further pushes.
                if (addr_q != '1) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                hold_instr <= instr_mem[rd_ptr];
                hold_addr  <= addr_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (accept && !legal) begin
                err_q <= 1'b1;
                if (rej_q != 8'hFF) begin
                    rej_q <= rej_q + 8'd1;
                end
            end
        end
    end

    // The popped head is kept so the outputs hold their last value once empty.
    assign out_instr = out_valid ? instr_mem[rd_ptr] : hold_instr;
    assign out_addr  = out_valid ? addr_mem[rd_ptr]  : hold_addr;
    assign err       = err_q;
    assign rej_count = rej_q;
    assign mem_full  = (state_q == STOP);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: queue-based reference model checked every cycle,
// directed vectors with literal expectations, plus a small-address instance.
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rn, in_rt;
    logic [63:0] in_imm;
    logic        out_valid, out_ready;
    logic [31:0] out_instr;
    logic [5:0]  out_addr;
    logic        err;
    logic [7:0]  rej_count;
    logic        mem_full;

    logic        in_valid2, in_ready2;
    logic [1:0]  in_kind2;
    logic [4:0]  in_rn2, in_rt2;
    logic [63:0] in_imm2;
    logic        out_valid2, out_ready2;
    logic [31:0] out_instr2;
    logic [1:0]  out_addr2;
    logic        err2;
    logic [7:0]  rej_count2;
    logic        mem_full2;

    int vectors = 0;
    int miscompares = 0;

    instr_encoder #(.DEPTH(4), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rn(in_rn), .in_rt(in_rt), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err), .rej_count(rej_count), .mem_full(mem_full)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_kind(in_kind2), .in_rn(in_rn2), .in_rt(in_rt2), .in_imm(in_imm2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
        .out_addr(out_addr2), .err(err2), .rej_count(rej_count2), .mem_full(mem_full2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference encoding from signed-range arithmetic and field placement.
    function automatic logic [32:0] model_enc(input logic [1:0] k, input logic [4:0] rn,
                                              input logic [4:0] rt, input logic [63:0] imm);
        longint      si;
        logic [31:0] w;
        logic        ok;
        si = $signed(imm);
        w  = '0;
        ok = 1'b0;
        case (k)
            2'd0, 2'd1: begin
                ok = (si >= -256) && (si <= 255);
                w  = ((k == 2'd0) ? 32'hF8400000 : 32'hF8000000)
                   | (32'(imm & 64'h1FF) << 12) | (32'(rn) << 5) | 32'(rt);
            end
            2'd2: begin
                ok = (si >= -262144) && (si <= 262143);
                w  = 32'hB4000000 | (32'(imm & 64'h7FFFF) << 5) | 32'(rt);
            end
            default: ;
        endcase
        return {ok, w};
    endfunction

    typedef struct packed {
        logic [31:0] instr;
        logic [5:0]  addr;
    } ent_t;

    ent_t   mq[$];
    ent_t   mlast;
    int     m_addr;
    bit     m_stop, m_err, m_started;
    int     m_rej;

    always @(posedge clk) begin
        bit          pop_m, acc_m;
        logic [32:0] r;
        if (reset) begin
            mq.delete();
            mlast     = '0;
            m_addr    = 0;
            m_stop    = 0;
            m_err     = 0;
            m_rej     = 0;
            m_started = 1;
        end else if (m_started) begin
            pop_m = (mq.size() != 0) && out_ready;
            acc_m = in_valid && !m_stop && (mq.size() < 4);
            if (pop_m) begin
                mlast = mq[0];
                void'(mq.pop_front());
            end
            if (acc_m) begin
                r = model_enc(in_kind, in_rn, in_rt, in_imm);
                if (r[32]) begin
                    mq.push_back('{instr: r[31:0], addr: 6'(m_addr)});
                    if (m_addr == 63) m_stop = 1;
                    else m_addr++;
                end else begin
                    m_err = 1;
                    if (m_rej < 255) m_rej++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("out_valid", out_valid, mq.size() != 0);
            chk("in_ready", in_ready, !m_stop && (mq.size() < 4));
            if (mq.size() != 0) begin
                chk("out_instr", out_instr, mq[0].instr);
                chk("out_addr", out_addr, mq[0].addr);
            end else begin
                chk("held_instr", out_instr, mlast.instr);
                chk("held_addr", out_addr, mlast.addr);
            end
            chk("err", err, m_err);
            chk("rej_count", rej_count, m_rej);
            chk("mem_full", mem_full, m_stop);
        end
    end

    int popped1[$];
    int popped2[$];
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready) popped1.push_back(int'(out_addr));
        if (!reset && out_valid2 === 1'b1 && out_ready2) popped2.push_back(int'(out_addr2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] k, input logic [4:0] rn, input logic [4:0] rt,
                         input logic [63:0] imm);
        in_valid = 1'b1;
        in_kind  = k;
        in_rn    = rn;
        in_rt    = rt;
        in_imm   = imm;
    endtask

    task automatic wait_accept();
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic send(input logic [1:0] k, input logic [4:0] rn, input logic [4:0] rt,
                        input logic [63:0] imm);
        drive(k, rn, rt, imm);
        wait_accept();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] sx;
        reset = 1'b1;
        in_valid = 1'b0; in_kind = '0; in_rn = '0; in_rt = '0; in_imm = '0;
        out_ready = 1'b0;
        in_valid2 = 1'b0; in_kind2 = '0; in_rn2 = '0; in_rt2 = '0; in_imm2 = '0;
        out_ready2 = 1'b0;

        chk("model_ldur", model_enc(2'd0, 5'd5, 5'd13, 64'h51), {1'b1, 32'hF84510AD});
        chk("model_stur", model_enc(2'd1, 5'd5, 5'd13, 64'h51), {1'b1, 32'hF80510AD});
        chk("model_cbz", model_enc(2'd2, 5'd0, 5'd0, 64'hFFFFFFFFFFFD8BA1), {1'b1, 32'hB4B17420});
        chk("model_ldur_oor", model_enc(2'd0, 5'd1, 5'd1, 64'd256) >> 32, 64'd0);

        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_rej", rej_count, 0);
        chk("rst_mem_full", mem_full, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();

        // LDUR then STUR, held, then drained
        send(2'd0, 5'd5, 5'd13, 64'h51);
        @(negedge clk);
        chk("ldur_valid_next", out_valid, 1);
        chk("ldur_instr", out_instr, 32'hF84510AD);
        chk("ldur_addr", out_addr, 0);
        tick();
        send(2'd1, 5'd5, 5'd13, 64'h51);
        @(negedge clk);
        chk("ldur_still_head", out_instr, 32'hF84510AD);
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("stur_instr", out_instr, 32'hF80510AD);
        chk("stur_addr", out_addr, 1);
        tick();

        // CBZ and range boundaries with the consumer always ready
        send(2'd2, 5'd0, 5'd0, 64'hFFFFFFFFFFFD8BA1);
        @(negedge clk);
        chk("cbz_instr", out_instr, 32'hB4B17420);
        chk("cbz_addr", out_addr, 2);
        sx = {{45{out_instr[23]}}, out_instr[23:5]};
        chk("cbz_signext", sx, 64'hFFFFFFFFFFFD8BA1);
        tick();
        send(2'd0, 5'd1, 5'd2, 64'hFFFFFFFFFFFFFF00);
        @(negedge clk);
        chk("ldur_m256", out_instr, 32'hF8500022);
        tick();
        send(2'd0, 5'd3, 5'd4, 64'd255);
        @(negedge clk);
        chk("ldur_255", out_instr, 32'hF84FF064);
        tick();
        send(2'd2, 5'd0, 5'd7, 64'hFFFFFFFFFFFC0000);
        @(negedge clk);
        chk("cbz_min", out_instr, 32'hB4800007);
        chk("cbz_min_addr", out_addr, 5);
        tick(); tick();

        // Illegal beats are consumed without pushing
        do_reset();
        send(2'd0, 5'd1, 5'd1, 64'd256);
        send(2'd2, 5'd0, 5'd0, 64'h40000);
        send(2'd3, 5'd0, 5'd0, 64'd0);
        @(negedge clk);
        chk("ill_err", err, 1);
        chk("ill_rej", rej_count, 3);
        chk("ill_no_push", out_valid, 0);
        tick();
        send(2'd0, 5'd5, 5'd13, 64'h51);
        @(negedge clk);
        chk("ill_next_addr", out_addr, 0);
        chk("ill_next_valid", out_valid, 1);
        tick(); tick();

        // Backpressure: fill, hold a fifth beat, then release
        do_reset();
        out_ready = 1'b0;
        popped1.delete();
        for (int i = 0; i < 4; i++) send(2'd0, 5'(i), 5'(i), 64'(i));
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        tick();
        drive(2'd1, 5'd4, 5'd4, 64'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        wait_accept();
        repeat (8) tick();
        chk("drain_count", popped1.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < popped1.size()) chk("drain_order", popped1[i], i);
        end

        // Reset with entries queued
        do_reset();
        out_ready = 1'b0;
        send(2'd3, 5'd0, 5'd0, 64'd0);
        for (int i = 0; i < 3; i++) send(2'd0, 5'd1, 5'(i), 64'(i));
        @(negedge clk);
        chk("pre_rst_err", err, 1);
        tick();
        do_reset();
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_rej", rej_count, 0);
        tick();
        out_ready = 1'b1;
        send(2'd1, 5'd2, 5'd3, 64'd8);
        @(negedge clk);
        chk("post_rst_addr", out_addr, 0);
        chk("post_rst_instr", out_instr, 32'hF8008043);
        tick(); tick();

        // Small address space: four words fill imem
        popped2.delete();
        out_ready2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid2 = 1'b1;
            in_kind2  = 2'd0;
            in_rn2    = 5'(i);
            in_rt2    = 5'(i);
            in_imm2   = 64'(i);
            @(negedge clk);
            chk("d2_in_ready", in_ready2, 1);
            chk("d2_not_full", mem_full2, 0);
            tick();
        end
        in_imm2 = 64'd4;
        @(negedge clk);
        chk("d2_mem_full", mem_full2, 1);
        chk("d2_stop_ready", in_ready2, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("d2_stop_hold", in_ready2, 0);
        end
        in_valid2 = 1'b0;
        tick();
        chk("d2_pop_count", popped2.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < popped2.size()) chk("d2_order", popped2[i], i);
        end
        chk("d2_err", err2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
